xor_sign_compare: RTL and testbench

- G.726 ADPCM sign-comparison block (ITU-T "XOR" function) for the adaptive predictor coefficient update path, used by both encoder and decoder.
- Computes Un = sign of current quantized difference DQ XOR sign of a delayed quantized difference DQn.
- Output path is purely combinational.
- Also carries a scan capture/shift structure, compiled in by macro, so the sign path can be observed in test mode.

---
 rtl/xor_sign_compare_if.sv | 13 +
 rtl/xor_sign_compare.sv | 69 ++++++
 tb/tb_xor_sign_compare.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/xor_sign_compare_if.sv
// Bus between the predictor datapath and the G.726 sign comparator:
// the two quantized differences in and the Un sign-comparison result out.
interface xor_sign_compare_if #(
  parameter int DQ_W  = 16,
  parameter int DQN_W = 11
);
  logic [DQ_W-1:0]  DQ;
  logic [DQN_W-1:0] DQn;
  logic             Un;

  modport master (output DQ, output DQn, input Un);
  modport slave  (input DQ, input DQn, output Un);
endinterface

// File: rtl/xor_sign_compare.sv
// G.726 sign comparison Un = sgn(DQ) ^ sgn(DQn), purely combinational.
// Define XOR_SCAN_CHAIN_EN to build the 28-bit capture/shift scan register.
module xor_sign_compare #(
  parameter int DQ_W  = 16,
  parameter int DQN_W = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   scan_in0,
  input  logic                   scan_in1,
  input  logic                   scan_in2,
  input  logic                   scan_in3,
  input  logic                   scan_in4,
  input  logic                   scan_enable,
  input  logic                   test_mode,
  xor_sign_compare_if.slave      bus,
  output logic                   scan_out0,
  output logic                   scan_out1,
  output logic                   scan_out2,
  output logic                   scan_out3,
  output logic                   scan_out4
);

  // Only the sign bits matter; a negative zero (e.g. DQ=0x8000) is negative.
  assign bus.Un = bus.DQ[DQ_W-1] ^ bus.DQn[DQN_W-1];

  logic [4:0] scan_in;
  logic [4:0] scan_out_vec;

  assign scan_in   = {scan_in4, scan_in3, scan_in2, scan_in1, scan_in0};
  assign scan_out0 = scan_out_vec[0];
  assign scan_out1 = scan_out_vec[1];
  assign scan_out2 = scan_out_vec[2];
  assign scan_out3 = scan_out_vec[3];
  assign scan_out4 = scan_out_vec[4];

`ifdef XOR_SCAN_CHAIN_EN
  localparam int SR_W = DQ_W + DQN_W + 1;

  logic [SR_W-1:0] sr_reg;
  logic [SR_W-1:0] capture_vec;
  logic [SR_W-1:0] shift_vec;

  assign capture_vec = {bus.DQ, bus.DQn, bus.Un};

  // Chains 0-3 are 6 bits wide from the top of SR; chain 4 holds the last 4.
  for (genvar gi = 0; gi < 5; gi++) begin : g_chain
    localparam int HI = SR_W - 1 - 6 * gi;
    localparam int LO = (gi == 4) ? 0 : HI - 5;

    assign shift_vec[HI:LO]  = {sr_reg[HI-1:LO], scan_in[gi]};
    assign scan_out_vec[gi]  = test_mode & sr_reg[HI];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sr_reg <= '0;
    end else if (test_mode) begin
      sr_reg <= scan_enable ? shift_vec : capture_vec;
    end
  end
`else
  assign scan_out_vec = '0;

  logic unused_scan_inputs;
  assign unused_scan_inputs = &{1'b0, clk, reset, scan_in, scan_enable, test_mode};
`endif

endmodule

// File: tb/tb_xor_sign_compare.sv
// Randomized self-checking bench for xor_sign_compare: a sign-rule model for Un
// and a per-chain bit-list model of the scan register, compared every cycle.
module tb_xor_sign_compare;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       reset;
  logic       scan_enable;
  logic       test_mode;
  logic [4:0] scan_in;
  wire        scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;
  wire  [4:0] scan_out = {scan_out4, scan_out3, scan_out2, scan_out1, scan_out0};

  xor_sign_compare_if #(.DQ_W(16), .DQN_W(11)) bus ();

  xor_sign_compare #(.DQ_W(16), .DQN_W(11)) dut (
    .clk         (clk),
    .reset       (reset),
    .scan_in0    (scan_in[0]),
    .scan_in1    (scan_in[1]),
    .scan_in2    (scan_in[2]),
    .scan_in3    (scan_in[3]),
    .scan_in4    (scan_in[4]),
    .scan_enable (scan_enable),
    .test_mode   (test_mode),
    .bus         (bus.slave),
    .scan_out0   (scan_out0),
    .scan_out1   (scan_out1),
    .scan_out2   (scan_out2),
    .scan_out3   (scan_out3),
    .scan_out4   (scan_out4)
  );

  int checks   = 0;
  int failures = 0;
  bit run_cmp  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Un from the arithmetic meaning: is each value on the negative side?
  function automatic logic model_un(input logic [15:0] dq, input logic [10:0] dqn);
    return (dq >= 16'h8000) != (dqn >= 11'h400);
  endfunction

  // Scan model: chain k is a list of bits, index 0 is the bit on scan_outk.
  int chain_len [5] = '{6, 6, 6, 6, 4};
  bit chain_m [5][6];

  always @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 5; k++)
        for (int j = 0; j < 6; j++) chain_m[k][j] = 1'b0;
    end else if (test_mode && !scan_enable) begin
      logic [27:0] vec;
      int pos;
      vec = {bus.DQ, bus.DQn, model_un(bus.DQ, bus.DQn)};
      pos = 27;
      for (int k = 0; k < 5; k++)
        for (int j = 0; j < chain_len[k]; j++) begin
          chain_m[k][j] = vec[pos];
          pos--;
        end
    end else if (test_mode) begin
      for (int k = 0; k < 5; k++) begin
        for (int j = 0; j < chain_len[k] - 1; j++) chain_m[k][j] = chain_m[k][j+1];
        chain_m[k][chain_len[k]-1] = scan_in[k];
      end
    end
  end

  function automatic logic [4:0] model_scan_out();
    logic [4:0] r;
    r = '0;
`ifdef XOR_SCAN_CHAIN_EN
    for (int k = 0; k < 5; k++) r[k] = test_mode & chain_m[k][0];
`endif
    return r;
  endfunction

  // Inputs change 1 ns after posedge; outputs are checked 10 ns later.
  always begin
    @(posedge clk);
    #11;
    if (run_cmp) begin
      chk("un_model", {31'd0, bus.Un}, {31'd0, model_un(bus.DQ, bus.DQn)});
      chk("scan_out_model", {27'd0, scan_out}, {27'd0, model_scan_out()});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] lit_dq  [4] = '{16'h0000, 16'h8000, 16'h7FFF, 16'h8123};
    logic [10:0] lit_dqn [4] = '{11'h000, 11'h000, 11'h400, 11'h7FF};
    logic        lit_un  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [5:0]  stream0;
    logic [5:0]  stream4;

    reset = 1'b0; test_mode = 1'b0; scan_enable = 1'b0; scan_in = '0;
    bus.DQ = '0; bus.DQn = '0;
    repeat (2) step();
    #10;
    chk("reset_scan_out", {27'd0, scan_out}, 32'd0);
    chk("reset_un", {31'd0, bus.Un}, 32'd0);
    step();
    run_cmp = 1'b1;

    for (int i = 0; i < 4; i++) begin
      bus.DQ = lit_dq[i]; bus.DQn = lit_dqn[i];
      #10;
      chk($sformatf("un_literal%0d", i), {31'd0, bus.Un}, {31'd0, lit_un[i]});
      step();
    end

    // Exhaustive DQ sweep under reset, sign of DQn alternating.
    for (int i = 0; i < 65536; i++) begin
      bus.DQ  = i[15:0];
      bus.DQn = i[0] ? 11'h400 : 11'h3FF;
      step();
    end

    // Capture then shift out two chains.
    reset = 1'b1; test_mode = 1'b1; scan_enable = 1'b0; scan_in = '0;
    bus.DQ = 16'hA5C3; bus.DQn = 11'h5A6;
    step();
    scan_enable = 1'b1;
`ifdef XOR_SCAN_CHAIN_EN
    stream0 = 6'b101001;
    stream4 = 6'b110000;
`else
    stream0 = 6'b000000;
    stream4 = 6'b000000;
`endif
    for (int i = 0; i < 6; i++) begin
      #10;
      chk($sformatf("stream0_bit%0d", i), {31'd0, scan_out0}, {31'd0, stream0[5-i]});
      chk($sformatf("stream4_bit%0d", i), {31'd0, scan_out4}, {31'd0, stream4[5-i]});
      step();
    end

    // Fill chain 2 with ones, then reset mid-shift.
    scan_in = 5'b00100;
    repeat (7) step();
    #10;
`ifdef XOR_SCAN_CHAIN_EN
    chk("chain2_ones", {31'd0, scan_out2}, 32'd1);
`else
    chk("chain2_ones", {31'd0, scan_out2}, 32'd0);
`endif
    step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    #10;
    chk("midshift_reset_out", {27'd0, scan_out}, 32'd0);
    chk("midshift_reset_un", {31'd0, bus.Un}, {31'd0, bus.DQ[15] ^ bus.DQn[10]});
    repeat (4) step();

    // Random traffic on every input.
    for (int n = 0; n < 3000; n++) begin
      bus.DQ      = 16'($urandom);
      bus.DQn     = 11'($urandom);
      scan_in     = 5'($urandom);
      scan_enable = 1'($urandom);
      test_mode   = ($urandom_range(0, 3) != 0);
      reset       = ($urandom_range(0, 31) != 0);
      step();
    end

    run_cmp = 1'b0;
    #20;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
